// File: rtl/fir_pkg.sv
// Shared types and width/limit helpers for the multi-channel FIR MAC engine.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } fir_state_e;

  // Channel tag width; a single channel still carries a 1-bit tag.
  function automatic int unsigned ch_width(input int unsigned nchan);
    return (nchan > 1) ? $clog2(nchan) : 1;
  endfunction

  // Smallest accumulator that cannot overflow for a full-length kernel.
  function automatic int unsigned acc_width_min(input int unsigned data_w,
                                                input int unsigned coef_w,
                                                input int unsigned addr_w);
    return data_w + coef_w + addr_w;
  endfunction

  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic right shift and saturate of the accumulator.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] result_c
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] RND = EXT_W'(longint'(1) << (OUT_SHIFT - 1));
  localparam logic signed [EXT_W-1:0] HI  = EXT_W'(sat_max(DATA_W));
  localparam logic signed [EXT_W-1:0] LO  = EXT_W'(sat_min(DATA_W));

  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;

  always_comb begin
    rounded = EXT_W'(acc) + RND;
    shifted = rounded >>> OUT_SHIFT;
    if (shifted > HI) begin
      result_c = HI[DATA_W-1:0];
    end else if (shifted < LO) begin
      result_c = LO[DATA_W-1:0];
    end else begin
      result_c = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/multichannel_fir.sv
// Multi-channel FIR MAC: convolves NCHAN circular sample buffers with one shared
// kernel, one tap per cycle, emitting a rounded/saturated result per channel.
module multichannel_fir
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned NCHAN     = 2,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned OUT_SHIFT = 15,
  localparam int unsigned CH_W     = ch_width(NCHAN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        buf_last,
  input  logic [ADDR_W-1:0]        taps_m1,
  output logic [CH_W+ADDR_W-1:0]   audio_addr,
  input  logic signed [DATA_W-1:0] audio_data,
  output logic [ADDR_W-1:0]        kernel_addr,
  input  logic signed [COEF_W-1:0] kernel_data,
  output logic [DATA_W-1:0]        result,
  output logic [CH_W-1:0]          result_chan,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCHAN - 1);

  if (ACC_W < acc_width_min(DATA_W, COEF_W, ADDR_W)) begin : g_acc_chk
    $error("multichannel_fir: ACC_W too narrow for DATA_W+COEF_W+ADDR_W");
  end

  fir_state_e               state;
  logic [ADDR_W-1:0]        start_q;
  logic [ADDR_W-1:0]        last_q;
  logic [ADDR_W-1:0]        taps_q;
  logic [ADDR_W-1:0]        buf_idx;
  logic [CH_W-1:0]          chan;
  logic                     drain_2nd;
  logic                     data_v;
  logic                     prod_v;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [DATA_W-1:0] rs_c;

  assign audio_addr = {chan, buf_idx};
  assign acc_sum    = acc + ACC_W'(prod);

  // The final tap's product lands in the last DRAIN cycle, so round the sum directly.
  fir_round_sat #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_round_sat (
    .acc     (acc_sum),
    .result_c(rs_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      start_q      <= '0;
      last_q       <= '0;
      taps_q       <= '0;
      buf_idx      <= '0;
      kernel_addr  <= '0;
      chan         <= '0;
      drain_2nd    <= 1'b0;
      data_v       <= 1'b0;
      prod_v       <= 1'b0;
      prod         <= '0;
      acc          <= '0;
      result       <= '0;
      result_chan  <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      data_v       <= (state == ST_RUN);
      prod_v       <= data_v;
      if (data_v) prod <= PROD_W'(audio_data) * PROD_W'(kernel_data);
      if (prod_v) acc <= acc_sum;

      case (state)
        ST_IDLE: begin
          if (start) begin
            start_q     <= start_addr;
            last_q      <= buf_last;
            taps_q      <= taps_m1;
            buf_idx     <= start_addr;
            kernel_addr <= '0;
            chan        <= '0;
            acc         <= '0;
            busy        <= 1'b1;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (kernel_addr == taps_q) begin
            drain_2nd <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            kernel_addr <= kernel_addr + ADDR_W'(1);
            buf_idx     <= (buf_idx == last_q) ? '0 : buf_idx + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          drain_2nd <= 1'b1;
          if (drain_2nd) begin
            result       <= rs_c;
            result_chan  <= chan;
            result_valid <= 1'b1;
            done         <= (chan == LAST_CH);
            state        <= ST_OUT;
          end
        end
        ST_OUT: begin
          acc <= '0;
          if (chan == LAST_CH) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            chan        <= chan + CH_W'(1);
            kernel_addr <= '0;
            buf_idx     <= start_q;
            state       <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multichannel_fir.sv
// Directed and randomized checks of multichannel_fir against a frame-level reference model.
module tb_multichannel_fir;

  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [6:0]        start_addr = '0;
  logic [6:0]        buf_last = '0;
  logic [6:0]        taps_m1 = '0;
  logic [7:0]        audio_addr;
  logic signed [15:0] audio_data;
  logic [6:0]        kernel_addr;
  logic signed [15:0] kernel_data;
  logic [15:0]       result;
  logic [0:0]        result_chan;
  logic              result_valid;
  logic              busy;
  logic              done;

  logic signed [15:0] mem [NCH][128];
  logic signed [15:0] kern [128];
  logic [15:0]        got_res [NCH];
  int n_assert = 0;
  int n_fail = 0;

  multichannel_fir dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .buf_last    (buf_last),
    .taps_m1     (taps_m1),
    .audio_addr  (audio_addr),
    .audio_data  (audio_data),
    .kernel_addr (kernel_addr),
    .kernel_data (kernel_data),
    .result      (result),
    .result_chan (result_chan),
    .result_valid(result_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge clk) begin
    audio_data  <= mem[audio_addr[7]][audio_addr[6:0]];
    kernel_data <= kern[kernel_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Convolution of one channel, then round-half-up, shift and clamp with plain integers.
  function automatic logic [15:0] ref_result(input int c, input logic [6:0] sa,
                                             input logic [6:0] bl, input logic [6:0] tm1);
    longint acc = 0;
    logic [6:0] idx = sa;
    for (int k = 0; k <= int'(tm1); k++) begin
      acc += longint'(mem[c][idx]) * longint'(kern[k]);
      idx = (idx == bl) ? 7'd0 : idx + 7'd1;
    end
    acc = (acc + (longint'(1) << 14)) >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  task automatic fill_random();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 128; i++) mem[c][i] = 16'($urandom);
    for (int i = 0; i < 128; i++) kern[i] = 16'($urandom);
  endtask

  // One frame, checking every cycle's handshake, addresses and results at negedge.
  task automatic run_frame(input logic [6:0] sa, input logic [6:0] bl,
                           input logic [6:0] tm1, input bit spam);
    int n = int'(tm1) + 1;
    int per = n + 3;
    int total = NCH * per;
    logic [6:0] idx [128];
    logic [6:0] t = sa;
    logic [15:0] exp_res [NCH];
    for (int k = 0; k < n; k++) begin
      idx[k] = t;
      t = (t == bl) ? 7'd0 : t + 7'd1;
    end
    for (int c = 0; c < NCH; c++) exp_res[c] = ref_result(c, sa, bl, tm1);
    @(negedge clk);
    start = 1'b1; start_addr = sa; buf_last = bl; taps_m1 = tm1;
    for (int j = 1; j <= total + 2; j++) begin
      int c = (j - 1) / per;
      int k = (j - 1) % per;
      bit exp_rv = (j % per == 0) && (j <= total);
      @(negedge clk);
      start = spam && (j < total);
      if (spam) begin
        start_addr = 7'($urandom); buf_last = 7'($urandom); taps_m1 = 7'($urandom);
      end
      chk("busy", 64'(busy), 64'(j <= total));
      chk("result_valid", 64'(result_valid), 64'(exp_rv));
      chk("done", 64'(done), 64'(j == total));
      if (exp_rv) begin
        int rc = j / per - 1;
        chk("result", 64'(result), 64'(exp_res[rc]));
        chk("result_chan", 64'(result_chan), 64'(rc));
        got_res[rc] = result;
      end
      if (j <= total && k < n) begin
        logic [7:0] ea = {c[0], idx[k]};
        chk("audio_addr", 64'(audio_addr), 64'(ea));
        chk("kernel_addr", 64'(kernel_addr), 64'(k));
      end
      if (j > total) chk("result_hold", 64'(result), 64'(exp_res[NCH-1]));
    end
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_rv"}, 64'(result_valid), 64'(0));
    chk({tag, "_result"}, 64'(result), 64'(0));
    chk({tag, "_chan"}, 64'(result_chan), 64'(0));
    chk({tag, "_aaddr"}, 64'(audio_addr), 64'(0));
    chk({tag, "_kaddr"}, 64'(kernel_addr), 64'(0));
  endtask

  initial begin
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 128; i++) mem[c][i] = '0;
    for (int i = 0; i < 128; i++) kern[i] = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Single tap: 0x2000 * 0x4000 and its negation.
    kern[0] = 16'h4000; mem[0][10] = 16'h2000; mem[1][10] = 16'hE000;
    run_frame(7'd10, 7'd127, 7'd0, 1'b0);
    chk("single_ch0", 64'(got_res[0]), 64'(16'h1000));
    chk("single_ch1", 64'(got_res[1]), 64'(16'hF000));

    // Buffer wrap at the end of the index space and at a short buffer.
    fill_random();
    run_frame(7'd126, 7'd127, 7'd3, 1'b0);
    run_frame(7'd5, 7'd5, 7'd3, 1'b0);

    // Saturation in both directions.
    for (int i = 0; i < 128; i++) begin
      mem[0][i] = 16'h7FFF; mem[1][i] = 16'h8001; kern[i] = 16'h7FFF;
    end
    run_frame(7'd0, 7'd127, 7'd3, 1'b0);
    chk("sat_pos", 64'(got_res[0]), 64'(16'h7FFF));
    chk("sat_neg", 64'(got_res[1]), 64'(16'h8000));

    // Half-LSB rounding: +2^14 rounds up to 1, -2^14 rounds up to 0.
    for (int i = 0; i < 128; i++) begin
      mem[0][i] = 16'h4000; mem[1][i] = 16'hC000;
    end
    kern[0] = 16'h0001;
    run_frame(7'd0, 7'd127, 7'd0, 1'b0);
    chk("round_pos", 64'(got_res[0]), 64'(16'h0001));
    chk("round_neg", 64'(got_res[1]), 64'(16'h0000));

    // start held high and config inputs churned while busy.
    fill_random();
    run_frame(7'(($urandom)), 7'(($urandom)), 7'd7, 1'b1);

    // Reset in cycle 5 of a 16-tap frame.
    @(negedge clk);
    start = 1'b1; start_addr = 7'd3; buf_last = 7'd90; taps_m1 = 7'd15;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == 5) reset = 1'b1;
    end
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      chk("post_reset_rv", 64'(result_valid), 64'(0));
      chk("post_reset_done", 64'(done), 64'(0));
      chk("post_reset_busy", 64'(busy), 64'(0));
    end
    run_frame(7'd3, 7'd90, 7'd15, 1'b0);

    // Random frames.
    for (int f = 0; f < 200; f++) begin
      fill_random();
      run_frame(7'($urandom), 7'($urandom), 7'($urandom_range(0, 31)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multichannel_fir.md
# multichannel_fir

Parametrised, multi-channel successor to the single-channel FIR MAC engine in the audio effects DSP path. On a `start` pulse it convolves each of `NCHAN` circular sample buffers against one shared coefficient kernel, one tap per cycle. The MAC is inferred, not a vendor IP block. Each channel's result is rounded, saturated and emitted with a channel tag. The block sits between the per-channel sample RAMs, the kernel ROM/RAM and the effects mixer.

## Interface
Parameters:
- `DATA_W`, 16: signed audio sample and result width.
- `COEF_W`, 16: signed coefficient width.
- `ADDR_W`, 7: buffer and kernel index width.
- `NCHAN`, 2: channel count, at least 1. `CH_W = max(1, clog2(NCHAN))`.
- `ACC_W`, 40: accumulator width. Must be at least `DATA_W + COEF_W + ADDR_W`.
- `OUT_SHIFT`, 15: right shift applied to the accumulator before saturation (Q15 coefficients).

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: pulse to begin a frame. Honoured only in IDLE.
- `start_addr`, in, ADDR_W: buffer index of tap 0.
- `buf_last`, in, ADDR_W: last buffer index. The buffer index wraps to 0 after this value.
- `taps_m1`, in, ADDR_W: tap count minus 1.
- `audio_addr`, out, CH_W+ADDR_W: `{channel, buffer index}`.
- `audio_data`, in, DATA_W: sample. Valid 1 cycle after `audio_addr`.
- `kernel_addr`, out, ADDR_W: coefficient index.
- `kernel_data`, in, COEF_W: coefficient. Valid 1 cycle after `kernel_addr`.
- `result`, out, DATA_W: rounded and saturated output.
- `result_chan`, out, CH_W: channel that `result` belongs to.
- `result_valid`, out, 1: 1-cycle pulse.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: 1-cycle pulse, coincident with the last channel's `result_valid`.

## Operation
- States:
  - IDLE: on `start`, go to RUN.
  - RUN: issue taps.
  - DRAIN: flush the pipeline.
  - OUT: emit one result. Go to RUN for the next channel, or to IDLE after the last channel.
- `start_addr`, `buf_last` and `taps_m1` are registered when `start` is accepted. Changes to these inputs mid-frame have no effect.
- Per channel c, tap k (k = 0..taps_m1):
  - `kernel_addr` = k.
  - The buffer index starts at `start_addr`. Each tap it goes to 0 if it equals `buf_last`, otherwise it increments.
  - If `start_addr > buf_last`, the index increments with natural ADDR_W overflow until it reaches `buf_last`.
- The accumulator clears at the start of each channel. Each tap adds the full-precision signed product, sign-extended to ACC_W.
- Output for each channel:
  - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, an arithmetic shift with round-half-up.
  - r is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Channels are processed in order 0..NCHAN-1 and all use the same kernel.
- `start` is ignored while `busy` is high. No queueing.
- Reset values, in any state: state is IDLE; `busy`, `done`, `result_valid` are 0; `result` and `result_chan` are 0; both addresses are 0; accumulator is 0.
- Reset mid-frame aborts the frame. No `result_valid` or `done` may follow it.

## Timing
- Let N = `taps_m1` + 1. Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Channel 0:
  - Addresses for tap k are presented in cycle 1+k.
  - Data arrives in cycle 2+k. The product register loads at the end of 2+k. The accumulator updates at the end of 3+k.
  - `result_valid` for channel 0 is high in cycle N+3.
- Each channel occupies N+3 cycles. Channel c+1 presents tap 0 in the cycle after channel c's `result_valid`.
- `done` is high in cycle NCHAN·(N+3). `busy` drops in the following cycle, when the block is in IDLE.
- The earliest accepted new `start` is the cycle after `done`.
- `result` and `result_chan` hold their values until the next `result_valid`.

## Structure
- Shared package `fir_pkg` holds:
  - the state encoding (IDLE, RUN, DRAIN, OUT);
  - the `CH_W` and `ACC_W` derivation;
  - the saturation limit constants.
- Sub-module `fir_round_sat`: combinational round, shift and saturate (ACC_W in, DATA_W out), registered in OUT by the parent.
- Pipeline registers, index counters and the FSM live in `multichannel_fir`.

## Test plan
- **Single tap:** NCHAN=2, `taps_m1`=0, kernel[0]=0x4000, ch0 sample=0x2000, ch1 sample=-0x2000 → results 0x1000 then 0xF000. `done` in cycle 8.
- **Wrap-around:** `start_addr`=126, `buf_last`=127, `taps_m1`=3 → buffer indices 126, 127, 0, 1 per channel. Then `buf_last`=5, `start_addr`=5 → indices 5, 0, 1, 2.
- **Saturation and rounding:** 4 taps, each sample 0x7FFF and coefficient 0x7FFF → result 0x7FFF. Negative case gives 0x8000. acc = 2^14 exactly → result 1.
- **Busy protection:** `start` pulsed every cycle during a frame, and `taps_m1` changed mid-frame → exactly NCHAN results and one `done`, using the latched `taps_m1`.
- **Reset mid-frame:** `reset` asserted in cycle 5 of a 16-tap frame → all outputs 0 next cycle, no `result_valid` afterward. A fresh `start` then produces correct results.
- **Random reference:** 200 frames with random taps, buffers and data compared against a golden model → bit-exact, channel tags in order.
